// File: rtl/register_file_mp.sv
// Multi-port register file: NUM_READ combinational read ports, two write ports (port 1 wins on collision).
// Reads are zero-latency, writes commit on the rising clock edge, and reset clears the array asynchronously.
module register_file_mp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ   = 2,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] read_reg,
  output logic [NUM_READ*DATA_WIDTH-1:0] read_data,
  input  logic                           write_enable_0,
  input  logic [ADDR_WIDTH-1:0]          write_reg_0,
  input  logic [DATA_WIDTH-1:0]          write_data_0,
  input  logic                           write_enable_1,
  input  logic [ADDR_WIDTH-1:0]          write_reg_1,
  input  logic [DATA_WIDTH-1:0]          write_data_1
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  if (NUM_READ < 1 || NUM_READ > 8) begin : g_bad_num_read
    $error("register_file_mp: NUM_READ must be in 1..8");
  end

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DATA_WIDTH-1:0] regs_d [DEPTH];
  logic                  we0_eff;
  logic                  we1_eff;

  // A write aimed at a hardwired zero register is treated as if it never happened.
  always_comb begin
    we0_eff = write_enable_0 && !reset;
    we1_eff = write_enable_1 && !reset;
    if (ZERO_REG != 0) begin
      if (write_reg_0 == '0) we0_eff = 1'b0;
      if (write_reg_1 == '0) we1_eff = 1'b0;
    end
  end

  // Port 1 is applied last so it overrides port 0 on an address collision.
  always_comb begin
    regs_d = regs_q;
    if (we0_eff) regs_d[write_reg_0] = write_data_0;
    if (we1_eff) regs_d[write_reg_1] = write_data_1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_dat;

    assign rd_addr = read_reg[k*ADDR_WIDTH +: ADDR_WIDTH];

    always_comb begin
      rd_dat = regs_q[rd_addr];
      if (BYPASS != 0) begin
        if (we0_eff && (write_reg_0 == rd_addr)) rd_dat = write_data_0;
        if (we1_eff && (write_reg_1 == rd_addr)) rd_dat = write_data_1;
      end
      if ((ZERO_REG != 0) && (rd_addr == '0)) rd_dat = '0;
      if (reset) rd_dat = '0;
    end

    assign read_data[k*DATA_WIDTH +: DATA_WIDTH] = rd_dat;
  end

endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench for register_file_mp: a default build, a no-zero/no-bypass build sharing its stimulus,
// and a 64-bit, 8-entry, 4-read-port build.
module tb_register_file_mp;

  logic        clock;
  logic        reset;

  logic [9:0]  read_reg;
  logic [63:0] rd_dat_a;
  logic [63:0] rd_dat_b;
  logic        we0, we1;
  logic [4:0]  wr0, wr1;
  logic [31:0] wd0, wd1;

  logic [11:0]  w_read_reg;
  logic [255:0] w_read_data;
  logic         w_we0, w_we1;
  logic [2:0]   w_wr0, w_wr1;
  logic [63:0]  w_wd0, w_wd1;

  int n_checks = 0;
  int n_fail   = 0;

  register_file_mp u_dut (
    .clock(clock), .reset(reset), .read_reg(read_reg), .read_data(rd_dat_a),
    .write_enable_0(we0), .write_reg_0(wr0), .write_data_0(wd0),
    .write_enable_1(we1), .write_reg_1(wr1), .write_data_1(wd1)
  );

  register_file_mp #(.ZERO_REG(0), .BYPASS(0)) u_nz (
    .clock(clock), .reset(reset), .read_reg(read_reg), .read_data(rd_dat_b),
    .write_enable_0(we0), .write_reg_0(wr0), .write_data_0(wd0),
    .write_enable_1(we1), .write_reg_1(wr1), .write_data_1(wd1)
  );

  register_file_mp #(.DATA_WIDTH(64), .ADDR_WIDTH(3), .NUM_READ(4), .ZERO_REG(0), .BYPASS(1)) u_wide (
    .clock(clock), .reset(reset), .read_reg(w_read_reg), .read_data(w_read_data),
    .write_enable_0(w_we0), .write_reg_0(w_wr0), .write_data_0(w_wd0),
    .write_enable_1(w_we1), .write_reg_1(w_wr1), .write_data_1(w_wd1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
    read_reg = {a1, a0};
    #1;
  endtask

  // Both 32-bit builds on both ports: a = default build, b = ZERO_REG=0/BYPASS=0 build.
  task automatic chk_pair(input string tag, input logic [31:0] ea0, input logic [31:0] ea1,
                          input logic [31:0] eb0, input logic [31:0] eb1);
    check_eq({tag, ".a0"}, {32'h0, rd_dat_a[31:0]},  {32'h0, ea0});
    check_eq({tag, ".a1"}, {32'h0, rd_dat_a[63:32]}, {32'h0, ea1});
    check_eq({tag, ".b0"}, {32'h0, rd_dat_b[31:0]},  {32'h0, eb0});
    check_eq({tag, ".b1"}, {32'h0, rd_dat_b[63:32]}, {32'h0, eb1});
  endtask

  function automatic logic [63:0] pat(input int i);
    logic [31:0] v;
    v = 32'(i);
    return {v, ~v};
  endfunction

  task automatic chk_wide(input string tag, input int a0, input int a1, input int a2, input int a3);
    int addrs [4];
    addrs = '{a0, a1, a2, a3};
    w_read_reg = {3'(a3), 3'(a2), 3'(a1), 3'(a0)};
    #1;
    for (int k = 0; k < 4; k++) begin
      check_eq($sformatf("%s.p%0d", tag, k), w_read_data[k*64 +: 64], pat(addrs[k]));
    end
  endtask

  initial begin
    reset = 1'b0;
    read_reg = '0; we0 = 0; we1 = 0; wr0 = '0; wr1 = '0; wd0 = '0; wd1 = '0;
    w_read_reg = '0; w_we0 = 0; w_we1 = 0; w_wr0 = '0; w_wr1 = '0; w_wd0 = '0; w_wd1 = '0;

    #2 reset = 1'b1;
    set_rd(5'd5, 5'd31);
    chk_pair("rst_init", 0, 0, 0, 0);
    check_eq("rst_init.wide", w_read_data[63:0], 64'h0);
    #2 reset = 1'b0;
    tick();

    // Fill r5/r31, then assert reset between edges.
    we0 = 1; wr0 = 5'd5;  wd0 = 32'hDEAD_BEEF; tick();
    wr0 = 5'd31; tick();
    we0 = 0;
    set_rd(5'd5, 5'd31);
    chk_pair("pre_rst", 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    #2 reset = 1'b1;
    #1 chk_pair("async_rst", 0, 0, 0, 0);
    tick();

    // Write presented while reset is high: lost, and bypass is suppressed.
    we0 = 1; wr0 = 5'd5; wd0 = 32'h5555_0000;
    #1 chk_pair("rst_bypass", 0, 0, 0, 0);
    tick();
    we0 = 0; #2 reset = 1'b0;
    #1 chk_pair("rst_lost", 0, 0, 0, 0);
    tick();

    // Basic write/read through port 0.
    we0 = 1;
    wr0 = 5'd16; wd0 = 32'hFFFF_FFFF; tick();
    wr0 = 5'd17; wd0 = 32'hFFFF_EEEE; tick();
    wr0 = 5'd18; wd0 = 32'hEEEE_DDDD; tick();
    wr0 = 5'd19; wd0 = 32'hDDDD_CCCC; tick();
    we0 = 0;
    set_rd(5'd16, 5'd17);
    chk_pair("rd16_17", 32'hFFFF_FFFF, 32'hFFFF_EEEE, 32'hFFFF_FFFF, 32'hFFFF_EEEE);
    set_rd(5'd18, 5'd19);
    chk_pair("rd18_19", 32'hEEEE_DDDD, 32'hDDDD_CCCC, 32'hEEEE_DDDD, 32'hDDDD_CCCC);

    // Dual write, then collision on r7.
    we0 = 1; wr0 = 5'd3; wd0 = 32'h1111_1111;
    we1 = 1; wr1 = 5'd4; wd1 = 32'h2222_2222; tick();
    wr0 = 5'd7; wd0 = 32'hAAAA_AAAA; wr1 = 5'd7; wd1 = 32'h5555_5555;
    set_rd(5'd7, 5'd7);
    chk_pair("coll_byp", 32'h5555_5555, 32'h5555_5555, 0, 0);
    tick();
    we0 = 0; we1 = 0;
    set_rd(5'd3, 5'd4);
    chk_pair("dual", 32'h1111_1111, 32'h2222_2222, 32'h1111_1111, 32'h2222_2222);
    set_rd(5'd7, 5'd16);
    chk_pair("coll", 32'h5555_5555, 32'hFFFF_FFFF, 32'h5555_5555, 32'hFFFF_FFFF);

    // Zero register.
    we1 = 1; wr1 = 5'd0; wd1 = 32'h1234_5678;
    set_rd(5'd0, 5'd0);
    chk_pair("zero_byp", 0, 0, 0, 0);
    tick();
    we1 = 0;
    #1 chk_pair("zero_post", 0, 0, 32'h1234_5678, 32'h1234_5678);

    // Bypass: r9 preloaded, then overwritten while read on port 1.
    we0 = 1; wr0 = 5'd9; wd0 = 32'h0000_0009; tick();
    wd0 = 32'hCAFE_0001;
    set_rd(5'd0, 5'd9);
    chk_pair("byp_pre", 0, 32'hCAFE_0001, 32'h1234_5678, 32'h0000_0009);
    tick();
    we0 = 0;
    #1 chk_pair("byp_post", 0, 32'hCAFE_0001, 32'h1234_5678, 32'hCAFE_0001);

    // Wide build: two registers per edge, then distinct four-port reads.
    for (int i = 0; i < 4; i++) begin
      w_we0 = 1; w_wr0 = 3'(i);     w_wd0 = pat(i);
      w_we1 = 1; w_wr1 = 3'(i + 4); w_wd1 = pat(i + 4);
      tick();
    end
    w_we0 = 0; w_we1 = 0;
    chk_wide("wide0123", 0, 1, 2, 3);
    chk_wide("wide4567", 4, 5, 6, 7);
    chk_wide("wide7250", 7, 2, 5, 0);
    chk_wide("wide3333", 3, 3, 3, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
